// File: rtl/tuple_if2_acc_if.sv
// Handshake bundle for tuple_if2_acc.
// master: tuple producer and output consumer (the bench or upstream glue).
// slave : the tuple_if2_acc stage.
// Signals: in_valid/in_ready with in_f1/in_f2/in_f3/in_sel and clear on the
// input side; out_valid/out_ready with out_pick/out_sum/out_cnt/out_sat on
// the output side.
interface tuple_if2_acc_if #(
  parameter int unsigned W     = 5,
  parameter int unsigned ACC_W = 8,
  parameter int unsigned CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_f1;
  logic [W-1:0]     in_f2;
  logic [W-1:0]     in_f3;
  logic [1:0]       in_sel;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [W:0]       out_pick;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_cnt;
  logic             out_sat;

  modport master (
    output in_valid, in_f1, in_f2, in_f3, in_sel, clear, out_ready,
    input  in_ready, out_valid, out_pick, out_sum, out_cnt, out_sat
  );

  modport slave (
    input  in_valid, in_f1, in_f2, in_f3, in_sel, clear, out_ready,
    output in_ready, out_valid, out_pick, out_sum, out_cnt, out_sat
  );
endinterface

// File: rtl/tuple_if2_acc.sv
// Two-stage tuple consumer: S1 registers {f1,f2,f3,sel}, S2 is the output
// register carrying the selected pick, a saturating running sum, a wrapping
// transaction count and a sticky saturation flag.
// Ports: clock (rising edge), reset (async, active-high), bus (slave modport
// of tuple_if2_acc_if; in_ready is the only combinational output).
module tuple_if2_acc #(
  parameter int unsigned W     = 5,
  parameter int unsigned ACC_W = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic            clock,
  input  logic            reset,
  tuple_if2_acc_if.slave  bus
);

  localparam int unsigned PW = W + 1;
  localparam int unsigned SW = ACC_W + 1;
  localparam logic [SW-1:0] ACC_MAX = {1'b0, {ACC_W{1'b1}}};

  logic             r_s1_valid;
  logic [W-1:0]     r_s1_f1;
  logic [W-1:0]     r_s1_f2;
  logic [W-1:0]     r_s1_f3;
  logic [1:0]       r_s1_sel;
  logic             r_out_valid;
  logic [PW-1:0]    r_pick;
  logic [ACC_W-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;

  logic             w_s2_free;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_xfer;
  logic [PW-1:0]    w_pick;
  logic [ACC_W-1:0] w_acc_base;
  logic [CNT_W-1:0] w_cnt_base;
  logic             w_sat_base;
  logic [SW-1:0]    w_acc_sum;
  logic             w_acc_ovf;

  // Handshake: S2 frees when empty or draining; S1 can take a tuple when it
  // is empty or moving on to S2 this cycle.
  assign w_s2_free  = !r_out_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_free;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_xfer     = r_s1_valid && w_s2_free;

  // Field select; sel 3 keeps the carry of f1+f2.
  always_comb begin
    w_pick = '0;
    case (r_s1_sel)
      2'd0:    w_pick = PW'(r_s1_f1);
      2'd1:    w_pick = PW'(r_s1_f2);
      2'd2:    w_pick = PW'(r_s1_f3);
      default: w_pick = PW'(r_s1_f1) + PW'(r_s1_f2);
    endcase
  end

  // A clear on a transfer cycle zeroes the state before the new pick lands.
  assign w_acc_base = bus.clear ? '0 : r_sum;
  assign w_cnt_base = bus.clear ? '0 : r_cnt;
  assign w_sat_base = bus.clear ? 1'b0 : r_sat;
  assign w_acc_sum  = SW'(w_acc_base) + SW'(w_pick);
  assign w_acc_ovf  = w_acc_sum > ACC_MAX;

  // Pipeline registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_f1     <= '0;
      r_s1_f2     <= '0;
      r_s1_f3     <= '0;
      r_s1_sel    <= '0;
      r_out_valid <= 1'b0;
      r_pick      <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_f1    <= bus.in_f1;
        r_s1_f2    <= bus.in_f2;
        r_s1_f3    <= bus.in_f3;
        r_s1_sel   <= bus.in_sel;
      end else if (w_xfer) begin
        r_s1_valid <= 1'b0;
      end

      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_pick      <= w_pick;
        r_sum       <= w_acc_ovf ? {ACC_W{1'b1}} : w_acc_sum[ACC_W-1:0];
        r_cnt       <= w_cnt_base + CNT_W'(1);
        r_sat       <= w_sat_base | w_acc_ovf;
      end else begin
        if (bus.out_ready) begin
          r_out_valid <= 1'b0;
        end
        if (bus.clear) begin
          r_sum <= '0;
          r_cnt <= '0;
          r_sat <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_pick  = r_pick;
  assign bus.out_sum   = r_sum;
  assign bus.out_cnt   = r_cnt;
  assign bus.out_sat   = r_sat;

endmodule

// File: tb/tb_tuple_if2_acc.sv
// Testbench for tuple_if2_acc: scoreboard of expected outputs, pushed on
// input accept and popped on each output handshake.
module tb_tuple_if2_acc;

  typedef struct packed {
    logic [5:0] pick;
    logic [7:0] sum;
    logic [3:0] cnt;
    logic       sat;
  } exp_t;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  exp_t sb[$];

  // Reference accumulator state, advanced in accept order.
  logic [7:0] m_acc;
  logic [3:0] m_cnt;
  logic       m_sat;

  tuple_if2_acc_if #(.W(5), .ACC_W(8), .CNT_W(4)) bus ();

  tuple_if2_acc #(.W(5), .ACC_W(8), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output monitor: a handshake seen at the falling edge completes at the
  // next rising edge, since the bench only changes inputs just after rising.
  always @(negedge clock) begin
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      exp_t got;
      exp_t want;
      got = {bus.out_pick, bus.out_sum, bus.out_cnt, bus.out_sat};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got pick=%0d sum=%0d cnt=%0d sat=%0b required=no output",
                 got.pick, got.sum, got.cnt, got.sat);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL sb_out got pick=%0d sum=%0d cnt=%0d sat=%0b required pick=%0d sum=%0d cnt=%0d sat=%0b",
                   got.pick, got.sum, got.cnt, got.sat, want.pick, want.sum, want.cnt, want.sat);
        end
      end
    end
  end

  task automatic model_zero();
    m_acc = '0;
    m_cnt = '0;
    m_sat = 1'b0;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_f1    = 'x;
    bus.in_f2    = 'x;
    bus.in_f3    = 'x;
    bus.in_sel   = 'x;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b1;
    idle();
    sb.delete();
    model_zero();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Offer one tuple, wait (bounded) for acceptance, push its expected result.
  // Called and returns at rising edge + 1; leaves in_valid high.
  task automatic send(input logic [4:0] f1, input logic [4:0] f2, input logic [4:0] f3,
                      input logic [1:0] sel, input bit clr, output int waited);
    exp_t       e;
    logic [5:0] p;
    logic [8:0] s;
    bus.in_valid = 1'b1;
    bus.in_f1    = f1;
    bus.in_f2    = f2;
    bus.in_f3    = f3;
    bus.in_sel   = sel;
    waited = 0;
    @(negedge clock);
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      waited++;
      @(negedge clock);
    end
    if (bus.in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready);
    end else begin
      case (sel)
        2'd0:    p = {1'b0, f1};
        2'd1:    p = {1'b0, f2};
        2'd2:    p = {1'b0, f3};
        default: p = {1'b0, f1} + {1'b0, f2};
      endcase
      if (clr) model_zero();
      s = {1'b0, m_acc} + {3'b000, p};
      if (s > 9'd255) begin
        m_acc = 8'd255;
        m_sat = 1'b1;
      end else begin
        m_acc = s[7:0];
      end
      m_cnt = m_cnt + 4'd1;
      e = '{pick: p, sum: m_acc, cnt: m_cnt, sat: m_sat};
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
  endtask

  task automatic test_reset();
    int w;
    do_reset();
    bus.out_ready = 1'b0;
    send(5'd30, 5'd20, 5'd17, 2'd0, 1'b0, w);
    idle();
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_valid got=%b required=1", bus.out_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b required=0", bus.out_valid); end
    total++;
    if (bus.out_sum !== 8'd0) begin bad++; $display("FAIL reset_sum got=%0d required=0", bus.out_sum); end
    total++;
    if (bus.out_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d required=0", bus.out_cnt); end
    total++;
    if (bus.out_sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b required=0", bus.out_sat); end
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b required=1", bus.in_ready); end
    total++;
    if (bus.out_pick !== 6'd0) begin bad++; $display("FAIL reset_pick got=%0d required=0", bus.out_pick); end
    sb.delete();
    model_zero();
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_single();
    int w;
    do_reset();
    send(5'd30, 5'd20, 5'd17, 2'd0, 1'b0, w);
    idle();
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b required=0", bus.out_valid); end
    @(posedge clock);
    #1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_pick !== 6'd30) begin
      bad++;
      $display("FAIL single_latency got valid=%b pick=%0d required valid=1 pick=30", bus.out_valid, bus.out_pick);
    end
    drain();
    send(5'd30, 5'd20, 5'd17, 2'd2, 1'b0, w);
    idle();
    drain();
    total++;
    if (bus.out_sum !== 8'd47 || bus.out_cnt !== 4'd2) begin
      bad++;
      $display("FAIL single_sum got sum=%0d cnt=%0d required sum=47 cnt=2", bus.out_sum, bus.out_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int stalls;
    do_reset();
    stalls = 0;
    send(5'd30, 5'd20, 5'd17, 2'd3, 1'b0, w); stalls += w;
    send(5'd30, 5'd20, 5'd17, 2'd1, 1'b0, w); stalls += w;
    send(5'd31, 5'd31, 5'd0,  2'd3, 1'b0, w); stalls += w;
    send(5'd1,  5'd2,  5'd9,  2'd2, 1'b0, w); stalls += w;
    idle();
    total++;
    if (stalls != 0) begin bad++; $display("FAIL b2b_stalls got=%0d required=0", stalls); end
    drain();
    total++;
    if (bus.out_sum !== 8'd141) begin bad++; $display("FAIL b2b_sum got=%0d required=141", bus.out_sum); end
  endtask

  task automatic test_backpressure();
    int w;
    do_reset();
    bus.out_ready = 1'b0;
    send(5'd30, 5'd20, 5'd17, 2'd0, 1'b0, w);
    send(5'd30, 5'd20, 5'd17, 2'd1, 1'b0, w);
    bus.in_sel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_pick !== 6'd30 || bus.out_sum !== 8'd30) begin
        bad++;
        $display("FAIL bp_hold got in_ready=%b valid=%b pick=%0d sum=%0d required 0 1 30 30",
                 bus.in_ready, bus.out_valid, bus.out_pick, bus.out_sum);
      end
    end
    @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    send(5'd30, 5'd20, 5'd17, 2'd2, 1'b0, w);
    idle();
    drain();
    total++;
    if (bus.out_sum !== 8'd67 || bus.out_cnt !== 4'd3) begin
      bad++;
      $display("FAIL bp_final got sum=%0d cnt=%0d required sum=67 cnt=3", bus.out_sum, bus.out_cnt);
    end
  endtask

  task automatic test_saturate();
    int w;
    do_reset();
    for (int i = 0; i < 16; i++) send(5'd31, 5'd31, 5'd0, 2'd3, 1'b0, w);
    idle();
    drain();
    total++;
    if (bus.out_cnt !== 4'd0 || bus.out_sat !== 1'b1 || bus.out_sum !== 8'd255) begin
      bad++;
      $display("FAIL sat_wrap got cnt=%0d sat=%b sum=%0d required cnt=0 sat=1 sum=255",
               bus.out_cnt, bus.out_sat, bus.out_sum);
    end
  endtask

  // Runs right after test_saturate so the clear has a set sat flag to drop.
  task automatic test_clear();
    int w;
    send(5'd30, 5'd20, 5'd17, 2'd2, 1'b1, w);
    idle();
    bus.clear = 1'b1;
    @(posedge clock);
    #1;
    bus.clear = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'd17 || bus.out_cnt !== 4'd1 || bus.out_sat !== 1'b0) begin
      bad++;
      $display("FAIL clear_xfer got valid=%b sum=%0d cnt=%0d sat=%b required 1 17 1 0",
               bus.out_valid, bus.out_sum, bus.out_cnt, bus.out_sat);
    end
    drain();
    bus.clear = 1'b1;
    @(posedge clock);
    #1;
    bus.clear = 1'b0;
    model_zero();
    total++;
    if (bus.out_sum !== 8'd0 || bus.out_cnt !== 4'd0 || bus.out_pick !== 6'd17 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL clear_idle got sum=%0d cnt=%0d pick=%0d valid=%b required 0 0 17 0",
               bus.out_sum, bus.out_cnt, bus.out_pick, bus.out_valid);
    end
  endtask

  task automatic test_reset_full();
    int w;
    bus.out_ready = 1'b0;
    send(5'd3, 5'd4, 5'd5, 2'd0, 1'b0, w);
    send(5'd3, 5'd4, 5'd5, 2'd1, 1'b0, w);
    idle();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_full got valid=%b in_ready=%b required valid=0 in_ready=1", bus.out_valid, bus.in_ready);
    end
    sb.delete();
    model_zero();
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rst_stale got valid=%b required=0", bus.out_valid);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b1;
    idle();
    model_zero();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_saturate();
    test_clear();
    test_reset_full();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
